// File: rtl/fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder
//
// Output reorder buffer for the tail of the 256-point radix-2^2 SDF FFT.
// The last pipeline stage delivers each frame in bit-reversed bin order. This
// block stores each frame into one bank of a two-bank (ping-pong) memory at
// the bit-reversed address, then reads the bank out linearly. The result is
// the frame in natural bin order, plus the bin index. While one bank drains,
// the other bank fills, so back-to-back frames stream out with no gap.
//
// Ports
//   clock      in   1       master clock, rising edge
//   reset_n    in   1       asynchronous assert, active-low reset
//   di_en      in   1       input sample valid, N consecutive cycles per frame
//   di_re      in   WIDTH   input sample real part, bit-reversed order
//   di_im      in   WIDTH   input sample imaginary part
//   do_en      out  1       output sample valid
//   do_re      out  WIDTH   output sample real part, natural order
//   do_im      out  WIDTH   output sample imaginary part
//   do_idx     out  N_LOG2  natural bin index of the current output sample
//   frame_err  out  1       one-cycle pulse: a partial input frame was dropped
// -----------------------------------------------------------------------------
module fft_bitrev_reorder #(
  parameter int WIDTH  = 16,
  parameter int N_LOG2 = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              di_en,
  input  logic [WIDTH-1:0]  di_re,
  input  logic [WIDTH-1:0]  di_im,
  output logic              do_en,
  output logic [WIDTH-1:0]  do_re,
  output logic [WIDTH-1:0]  do_im,
  output logic [N_LOG2-1:0] do_idx,
  output logic              frame_err
);

  localparam int N = 1 << N_LOG2;

  localparam logic [N_LOG2-1:0] CNT_ZERO = {N_LOG2{1'b0}};
  localparam logic [N_LOG2-1:0] CNT_ONE  = {{(N_LOG2-1){1'b0}}, 1'b1};
  localparam logic [N_LOG2-1:0] CNT_LAST = {N_LOG2{1'b1}};
  localparam logic [WIDTH-1:0]  DATA_ZERO = {WIDTH{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_e;

  // Mirror the bit order of a bin counter.
  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    r = CNT_ZERO;
    for (int i = 0; i < N_LOG2; i++) begin
      r[i] = v[N_LOG2-1-i];
    end
    return r;
  endfunction

  // Two banks stacked in one array. The bank select is the address MSB.
  logic [2*WIDTH-1:0] mem_r [0:2*N-1];

  // Write side state.
  logic [N_LOG2-1:0] wr_cnt_r;
  logic [N_LOG2-1:0] wr_cnt_s;
  logic              wr_bank_r;
  logic              wr_bank_s;
  logic              bank_done_s;
  logic              frame_err_r;
  logic              frame_err_s;

  // Bank-full flags, one per bank.
  logic [1:0]        full_r;
  logic [1:0]        full_s;

  // Read side state.
  rd_state_e         state_r;
  rd_state_e         state_s;
  logic [N_LOG2-1:0] rd_cnt_r;
  logic [N_LOG2-1:0] rd_cnt_s;
  logic              rd_bank_r;
  logic              rd_bank_s;
  logic              rd_active_s;
  logic              rd_done_s;

  // Registered outputs.
  logic              do_en_r;
  logic [WIDTH-1:0]  do_re_r;
  logic [WIDTH-1:0]  do_im_r;
  logic [N_LOG2-1:0] do_idx_r;

  // Write counter, bank toggle and partial-frame detection.
  always_comb begin
    wr_cnt_s    = wr_cnt_r;
    wr_bank_s   = wr_bank_r;
    bank_done_s = 1'b0;
    frame_err_s = 1'b0;
    if (di_en) begin
      if (wr_cnt_r == CNT_LAST) begin
        wr_cnt_s    = CNT_ZERO;
        wr_bank_s   = ~wr_bank_r;
        bank_done_s = 1'b1;
      end else begin
        wr_cnt_s = wr_cnt_r + CNT_ONE;
      end
    end else if (wr_cnt_r != CNT_ZERO) begin
      // The stream stopped mid-frame. The bank stays un-marked, so its
      // contents are simply overwritten by the next frame.
      wr_cnt_s    = CNT_ZERO;
      frame_err_s = 1'b1;
    end else begin
      wr_cnt_s = wr_cnt_r;
    end
  end

  // Read FSM next-state: pick a full bank, then sweep it linearly.
  always_comb begin
    state_s     = state_r;
    rd_cnt_s    = rd_cnt_r;
    rd_bank_s   = rd_bank_r;
    rd_active_s = 1'b0;
    rd_done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // If both banks are full, the one that wr_bank points at is the
        // older one, because the writer alternates between the banks.
        if (full_r[wr_bank_r]) begin
          state_s   = ST_READ;
          rd_bank_s = wr_bank_r;
          rd_cnt_s  = CNT_ZERO;
        end else if (full_r[~wr_bank_r]) begin
          state_s   = ST_READ;
          rd_bank_s = ~wr_bank_r;
          rd_cnt_s  = CNT_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        rd_active_s = 1'b1;
        if (rd_cnt_r == CNT_LAST) begin
          rd_done_s = 1'b1;
          rd_cnt_s  = CNT_ZERO;
          // Chain straight into the other bank so back-to-back frames
          // produce an unbroken do_en window.
          if (full_r[~rd_bank_r]) begin
            state_s   = ST_READ;
            rd_bank_s = ~rd_bank_r;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          rd_cnt_s = rd_cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        rd_cnt_s = CNT_ZERO;
      end
    endcase
  end

  // Bank-full flag update. The reader and writer always own different
  // banks, so the clear and the set never hit the same bit.
  always_comb begin
    full_s = full_r;
    if (rd_done_s) begin
      full_s[rd_bank_r] = 1'b0;
    end else begin
      full_s = full_r;
    end
    if (bank_done_s) begin
      full_s[wr_bank_r] = 1'b1;
    end else begin
      full_s[wr_bank_r] = full_s[wr_bank_r];
    end
  end

  // Sample storage: the sample goes in at the bit-reversed address.
  always_ff @(posedge clock) begin
    if (di_en) begin
      mem_r[{wr_bank_r, bitrev(wr_cnt_r)}] <= {di_re, di_im};
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_r    <= CNT_ZERO;
      wr_bank_r   <= 1'b0;
      frame_err_r <= 1'b0;
      full_r      <= 2'b00;
      state_r     <= ST_IDLE;
      rd_cnt_r    <= CNT_ZERO;
      rd_bank_r   <= 1'b0;
    end else begin
      wr_cnt_r    <= wr_cnt_s;
      wr_bank_r   <= wr_bank_s;
      frame_err_r <= frame_err_s;
      full_r      <= full_s;
      state_r     <= state_s;
      rd_cnt_r    <= rd_cnt_s;
      rd_bank_r   <= rd_bank_s;
    end
  end

  // Synchronous memory read into the output register. Outputs are forced
  // to zero whenever no sample is valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      do_en_r  <= 1'b0;
      do_re_r  <= DATA_ZERO;
      do_im_r  <= DATA_ZERO;
      do_idx_r <= CNT_ZERO;
    end else if (rd_active_s) begin
      do_en_r  <= 1'b1;
      {do_re_r, do_im_r} <= mem_r[{rd_bank_r, rd_cnt_r}];
      do_idx_r <= rd_cnt_r;
    end else begin
      do_en_r  <= 1'b0;
      do_re_r  <= DATA_ZERO;
      do_im_r  <= DATA_ZERO;
      do_idx_r <= CNT_ZERO;
    end
  end

  assign do_en     = do_en_r;
  assign do_re     = do_re_r;
  assign do_im     = do_im_r;
  assign do_idx    = do_idx_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// tb_fft_bitrev_reorder
//
// Self-checking bench for fft_bitrev_reorder. A reference model keeps a queue
// of the samples in the current input frame. When a frame completes, the model
// schedules the expected output for each future cycle: bin n is input sample
// bitrev(n), and the window starts two edges after the last input. Every cycle
// the model compares the DUT outputs against that schedule. A small table of
// directed scenarios also checks the valid counts, the longest unbroken valid
// run and the number of frame_err pulses.
// -----------------------------------------------------------------------------
module tb_fft_bitrev_reorder;

  localparam int WIDTH  = 16;
  localparam int N_LOG2 = 8;
  localparam int N      = 256;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              di_en;
  logic [WIDTH-1:0]  di_re;
  logic [WIDTH-1:0]  di_im;
  logic              do_en;
  logic [WIDTH-1:0]  do_re;
  logic [WIDTH-1:0]  do_im;
  logic [N_LOG2-1:0] do_idx;
  logic              frame_err;

  fft_bitrev_reorder #(.WIDTH(WIDTH), .N_LOG2(N_LOG2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .di_en     (di_en),
    .di_re     (di_re),
    .di_im     (di_im),
    .do_en     (do_en),
    .do_re     (do_re),
    .do_im     (do_im),
    .do_idx    (do_idx),
    .frame_err (frame_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [WIDTH-1:0]  re;
    logic [WIDTH-1:0]  im;
    logic [N_LOG2-1:0] idx;
  } exp_t;

  typedef struct {
    int nframes;   // frames sent back-to-back
    int len;       // samples per frame (less than N means a partial frame)
    int mode;      // 0: re=k, im=-k; 1: re={f,k}, im=-re; 2: random
    int exp_en;    // expected number of do_en cycles
    int exp_err;   // expected number of frame_err pulses
    int exp_run;   // expected longest unbroken do_en run
  } vec_t;

  vec_t vecs[4];

  int tests_run;
  int tests_failed;
  int edge_cnt;
  int en_cnt;
  int err_cnt;
  int run_len;
  int max_run;
  logic [WIDTH-1:0] cap_re[4];

  logic [2*WIDTH-1:0] cur[$];
  exp_t exp_q[int];
  bit   err_q[int];

  task automatic check(input bit ok, input string name, input string detail);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic int brev(input int v);
    int r;
    r = 0;
    for (int b = 0; b < N_LOG2; b++) begin
      r = (r * 2) + ((v >> b) & 1);
    end
    return r;
  endfunction

  task automatic model_clear();
    cur.delete();
    exp_q.delete();
    err_q.delete();
  endtask

  // Reference model: react to the inputs accepted at this edge.
  task automatic model_step();
    exp_t e;
    logic [2*WIDTH-1:0] s;
    if (reset_n) begin
      if (di_en) begin
        cur.push_back({di_re, di_im});
        if (cur.size() == N) begin
          for (int n = 0; n < N; n++) begin
            s     = cur[brev(n)];
            e.re  = s[2*WIDTH-1:WIDTH];
            e.im  = s[WIDTH-1:0];
            e.idx = N_LOG2'(n);
            exp_q[edge_cnt + 2 + n] = e;
          end
          cur.delete();
        end
      end else if (cur.size() != 0) begin
        err_q[edge_cnt] = 1'b1;
        cur.delete();
      end
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    bit   exp_err;
    if (exp_q.exists(edge_cnt)) begin
      e = exp_q[edge_cnt];
      exp_q.delete(edge_cnt);
      check(do_en === 1'b1 && do_idx === e.idx && do_re === e.re && do_im === e.im,
            "out_data",
            $sformatf("edge %0d got en=%0b idx=%0d re=%h im=%h, want en=1 idx=%0d re=%h im=%h",
                      edge_cnt, do_en, do_idx, do_re, do_im, e.idx, e.re, e.im));
    end else begin
      check(do_en === 1'b0 && do_idx === 8'd0 && do_re === 16'd0 && do_im === 16'd0,
            "out_idle",
            $sformatf("edge %0d got en=%0b idx=%0d re=%h im=%h, want all zero",
                      edge_cnt, do_en, do_idx, do_re, do_im));
    end
    exp_err = err_q.exists(edge_cnt);
    if (exp_err) begin
      err_q.delete(edge_cnt);
    end
    check(frame_err === exp_err, "frame_err",
          $sformatf("edge %0d got %0b want %0b", edge_cnt, frame_err, exp_err));
    // Statistics for the scenario table.
    if (do_en === 1'b1) begin
      en_cnt++;
      run_len++;
      if (do_idx < 8'd4) begin
        cap_re[do_idx[1:0]] = do_re;
      end
    end else begin
      run_len = 0;
    end
    if (run_len > max_run) begin
      max_run = run_len;
    end
    if (frame_err === 1'b1) begin
      err_cnt++;
    end
  endtask

  // One clock: drive on the falling edge, step the model on the rising edge,
  // then check outputs shortly after it.
  task automatic cycle(input logic rst_v, input logic en,
                       input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im);
    @(negedge clock);
    if (reset_n === 1'b1 && rst_v === 1'b0) begin
      reset_n = 1'b0;
      model_clear();
      #1;
      check(do_en === 1'b0 && do_re === 16'd0 && do_im === 16'd0 &&
            do_idx === 8'd0 && frame_err === 1'b0, "reset_async",
            $sformatf("got en=%0b re=%h im=%h idx=%0d err=%0b, want all zero",
                      do_en, do_re, do_im, do_idx, frame_err));
    end else begin
      reset_n = rst_v;
    end
    di_en = en;
    di_re = re;
    di_im = im;
    @(posedge clock);
    edge_cnt++;
    model_step();
    #2;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b0, 16'($urandom), 16'($urandom));
    end
  endtask

  task automatic send_frame(input int len, input int mode, input int tag);
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    for (int k = 0; k < len; k++) begin
      case (mode)
        0: begin
          re = 16'(k);
          im = 16'd0 - re;
        end
        1: begin
          re = {8'(tag), 8'(k)};
          im = 16'd0 - re;
        end
        default: begin
          re = 16'($urandom);
          im = 16'($urandom);
        end
      endcase
      cycle(1'b1, 1'b1, re, im);
    end
  endtask

  initial begin
    int en0;
    int err0;
    reset_n      = 1'b0;
    di_en        = 1'b0;
    di_re        = 16'd0;
    di_im        = 16'd0;
    tests_run    = 0;
    tests_failed = 0;
    edge_cnt     = 0;
    en_cnt       = 0;
    err_cnt      = 0;
    run_len      = 0;
    max_run      = 0;
    for (int i = 0; i < 4; i++) begin
      cap_re[i] = 16'hxxxx;
    end

    vecs[0] = '{nframes: 1, len: 256, mode: 0, exp_en: 256,  exp_err: 0, exp_run: 256};
    vecs[1] = '{nframes: 4, len: 256, mode: 1, exp_en: 1024, exp_err: 0, exp_run: 1024};
    vecs[2] = '{nframes: 1, len: 100, mode: 2, exp_en: 0,    exp_err: 1, exp_run: 0};
    vecs[3] = '{nframes: 1, len: 256, mode: 2, exp_en: 256,  exp_err: 0, exp_run: 256};

    // Reset held with random inputs, then released with di_en low.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    end
    idle(5);

    // Directed scenario table.
    for (int v = 0; v < 4; v++) begin
      en0     = en_cnt;
      err0    = err_cnt;
      max_run = 0;
      for (int f = 0; f < vecs[v].nframes; f++) begin
        send_frame(vecs[v].len, vecs[v].mode, f);
      end
      idle(300);
      check(en_cnt - en0 == vecs[v].exp_en, "vec_en_count",
            $sformatf("vec %0d got %0d want %0d", v, en_cnt - en0, vecs[v].exp_en));
      check(err_cnt - err0 == vecs[v].exp_err, "vec_err_count",
            $sformatf("vec %0d got %0d want %0d", v, err_cnt - err0, vecs[v].exp_err));
      check(max_run == vecs[v].exp_run, "vec_max_run",
            $sformatf("vec %0d got %0d want %0d", v, max_run, vecs[v].exp_run));
      if (v == 0) begin
        // Ramp input in bit-reversed order: do_re must read bitrev(do_idx).
        check(cap_re[0] === 16'd0 && cap_re[1] === 16'd128 &&
              cap_re[2] === 16'd64 && cap_re[3] === 16'd192, "ramp_head",
              $sformatf("got %0d,%0d,%0d,%0d want 0,128,64,192",
                        cap_re[0], cap_re[1], cap_re[2], cap_re[3]));
      end
    end

    // Reset at input sample 50 of frame 2 while frame 1 is being output.
    err0 = err_cnt;
    send_frame(256, 2, 0);
    send_frame(50, 2, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    end
    idle(5);
    check(err_cnt == err0, "reset_no_err",
          $sformatf("got %0d frame_err pulses want 0", err_cnt - err0));
    en0     = en_cnt;
    max_run = 0;
    send_frame(256, 0, 0);
    idle(300);
    check(en_cnt - en0 == 256 && max_run == 256, "post_reset_frame",
          $sformatf("got en=%0d run=%0d want 256/256", en_cnt - en0, max_run));

    // Random frames with random 1..20-cycle idle gaps.
    en0 = en_cnt;
    for (int f = 0; f < 50; f++) begin
      send_frame(256, 2, f);
      idle(int'($urandom_range(1, 20)));
    end
    idle(300);
    check(en_cnt - en0 == 50 * 256, "random_en_count",
          $sformatf("got %0d want %0d", en_cnt - en0, 50 * 256));

    check(exp_q.size() == 0 && err_q.size() == 0, "model_drained",
          $sformatf("got %0d outputs and %0d errors still pending, want 0",
                    exp_q.size(), err_q.size()));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
